led_game_sequencer: RTL and testbench
=====================================

LED_GAME_SEQUENCER -- requirements
Module: led_game_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in steps (2..15).
REQ-002 Parameter ON_TICKS, default 4, clk cycles a pattern LED is lit during playback.
REQ-003 Parameter OFF_TICKS, default 2, clk cycles all LEDs are dark between playback steps.
REQ-004 Parameter TIMEOUT_TICKS, default 64, clk cycles allowed between accepted presses in input phase.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a new game.
REQ-008 btn  input  4  debounced, synchronous button levels, bit i = button i.
REQ-009 led  output  4  LED drive, bit i = LED i.
REQ-010 busy  output  1  high in every state except IDLE, WIN, LOSE.
REQ-011 win  output  1  high while in WIN.
REQ-012 lose  output  1  high while in LOSE.
REQ-013 round  output  4  current pattern length, 0 in IDLE.
REQ-014 score  output  4  rounds completed in the current or last game.

Function
REQ-015 States: IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
REQ-016 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle, including in IDLE.
REQ-017 IDLE/WIN/LOSE + start=1 -> GEN next cycle; round<=1, score<=0, step index<=0.
REQ-018 start ignored while busy=1.
REQ-019 GEN: exactly one cycle; mem[round-1]<=lfsr[1:0]; entries 0..round-2 unchanged; -> SHOW_ON, index<=0.
REQ-020 SHOW_ON: led = one-hot(mem[index]) for exactly ON_TICKS cycles, then -> SHOW_OFF.
REQ-021 SHOW_OFF: led=0 for exactly OFF_TICKS cycles; then index==round-1 -> WAIT_IN with index<=0 and timer cleared, else index+1 -> SHOW_ON.
REQ-022 Press event = cycle where registered previous btn==0 and btn!=0; previous btn register updates every cycle in all states.
REQ-023 Buttons held on WAIT_IN entry produce no event until released and pressed again.
REQ-024 WAIT_IN: led = btn.
REQ-025 Correct event (btn one-hot equal to one-hot(mem[index])): timer cleared; index+1 if index<round-1.
REQ-026 Correct event with index==round-1: score+1; round==MAX_LEN -> WIN, else round+1 -> GEN.
REQ-027 Wrong-button event or multi-hot event -> LOSE.
REQ-028 Timer reaching TIMEOUT_TICKS without an event -> LOSE.
REQ-029 Event and timeout in the same cycle: event takes priority.
REQ-030 WIN: led=4'b1111; LOSE: led=4'b0000; round and score hold final values.
REQ-031 Press events outside WAIT_IN have no effect.
REQ-032 score and round saturate at MAX_LEN; counters never wrap.

Reset
REQ-033 rst asserted: state=IDLE, led=0, busy=0, win=0, lose=0, round=0, score=0, index=0, timer=0, lfsr=8'hA5, previous btn=0.
REQ-034 Pattern memory contents are not reset.
REQ-035 rst mid-game aborts immediately; first post-reset cycle is IDLE.

Structure
REQ-036 Shared package holds the state enumeration, LFSR seed/tap constants, and the 2-to-4 one-hot decode function.
REQ-037 One sub-module, game_lfsr8: free-running LFSR with synchronous outputs and async reset.

Verification
REQ-038 Reset then start at cycle 10 -> busy=1 at cycle 11, GEN one cycle, led one-hot = LFSR model [1:0] for 4 cycles, then 0 for 2 cycles.
REQ-039 Round 1: correct button pressed and released -> score=1, round=2, two playback steps, first step equal to round 1.
REQ-040 Round 2: wrong button on step 0 -> lose=1, led=0, busy=0, score=1.
REQ-041 No press for 64 cycles in WAIT_IN -> LOSE at cycle 64; press at cycle 63 -> accepted, timer cleared.
REQ-042 MAX_LEN=2, all presses correct -> win=1, led=4'b1111, score=2; start -> new game, round=1, score=0.
REQ-043 btn=4'b0011 pressed in WAIT_IN -> LOSE; rst during SHOW_ON -> IDLE, led=0 next cycle.

Source files
------------

// File: rtl/led_game_sequencer_pkg.sv
// Shared definitions for the LED memory game: FSM states, LFSR constants
// and the 2-to-4 one-hot decode used by both playback and input checking.
package led_game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 -> register bits 7, 5, 4, 3 feed the XOR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/led_game_sequencer_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; only the two low bits leave the block
// because a pattern step needs nothing more than a button number.
module game_lfsr8
  import led_game_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] sym
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign sym = lfsr_q[1:0];

endmodule

// File: rtl/led_game_sequencer.sv
// Simon-style LED game: grows a random pattern one step per round, plays it
// back on the LEDs and checks the player's button presses against it.
module led_game_sequencer
  import led_game_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned ON_TICKS      = 4,
  parameter int unsigned OFF_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [3:0] round,
  output logic [3:0] score
);

  localparam logic [3:0]  MAX_LEN4 = 4'(MAX_LEN);
  localparam logic [15:0] ON_LAST  = 16'(ON_TICKS - 1);
  localparam logic [15:0] OFF_LAST = 16'(OFF_TICKS - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);

  state_e      state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] tmr_q, tmr_d;
  logic [3:0]  btn_prev_q;
  logic [1:0]  mem_q [16];
  logic        mem_we;
  logic [1:0]  lfsr_sym;
  logic        press;
  logic        last_step;
  logic [3:0]  exp_btn;

  game_lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .sym (lfsr_sym)
  );

  // tmr_q counts playback ticks in SHOW_ON/SHOW_OFF and idle cycles in WAIT_IN.
  always_comb begin
    press     = (btn_prev_q == 4'b0000) && (btn != 4'b0000);
    exp_btn   = onehot4(mem_q[idx_q]);
    last_step = (idx_q == round_q - 4'd1);
    state_d   = state_q;
    round_d   = round_q;
    score_d   = score_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_GEN;
          round_d = 4'd1;
          score_d = 4'd0;
          idx_d   = 4'd0;
          tmr_d   = 16'd0;
        end
      end
      ST_GEN: begin
        mem_we  = 1'b1;
        state_d = ST_SHOW_ON;
        idx_d   = 4'd0;
        tmr_d   = 16'd0;
      end
      ST_SHOW_ON: begin
        if (tmr_q == ON_LAST) begin
          state_d = ST_SHOW_OFF;
          tmr_d   = 16'd0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_SHOW_OFF: begin
        if (tmr_q == OFF_LAST) begin
          tmr_d = 16'd0;
          if (last_step) begin
            state_d = ST_WAIT_IN;
            idx_d   = 4'd0;
          end else begin
            state_d = ST_SHOW_ON;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_WAIT_IN: begin
        // A press wins over an expiring timer in the same cycle.
        if (press) begin
          if (btn == exp_btn) begin
            tmr_d = 16'd0;
            if (last_step) begin
              score_d = (score_q < MAX_LEN4) ? score_q + 4'd1 : score_q;
              if (round_q >= MAX_LEN4) begin
                state_d = ST_WIN;
              end else begin
                round_d = round_q + 4'd1;
                state_d = ST_GEN;
              end
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = ST_LOSE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= 4'd0;
      score_q    <= 4'd0;
      idx_q      <= 4'd0;
      tmr_q      <= 16'd0;
      btn_prev_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      score_q    <= score_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      btn_prev_q <= btn;
    end
  end

  // Pattern memory keeps its contents across reset; a new game overwrites it in order.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[round_q - 4'd1] <= lfsr_sym;
  end

  always_comb begin
    case (state_q)
      ST_SHOW_ON: led = exp_btn;
      ST_WAIT_IN: led = btn;
      ST_WIN:     led = 4'b1111;
      default:    led = 4'b0000;
    endcase
    busy = !(state_q inside {ST_IDLE, ST_WIN, ST_LOSE});
    win  = (state_q == ST_WIN);
    lose = (state_q == ST_LOSE);
  end

  assign round = round_q;
  assign score = score_q;

endmodule

// File: tb/tb_led_game_sequencer.sv
// Directed bench for led_game_sequencer: a phase/countdown game model predicts
// every output each cycle, and literal checks pin the model at key points.
module tb_led_game_sequencer;

  localparam int MAX_LEN       = 2;
  localparam int ON_TICKS      = 4;
  localparam int OFF_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 64;

  localparam int P_IDLE = 0, P_GEN = 1, P_ON = 2, P_OFF = 3;
  localparam int P_WAIT = 4, P_WIN = 5, P_LOSE = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] led;
  logic       busy;
  logic       win;
  logic       lose;
  logic [3:0] round;
  logic [3:0] score;

  led_game_sequencer #(
    .MAX_LEN       (MAX_LEN),
    .ON_TICKS      (ON_TICKS),
    .OFF_TICKS     (OFF_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .btn   (btn),
    .led   (led),
    .busy  (busy),
    .win   (win),
    .lose  (lose),
    .round (round),
    .score (score)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // ---------------- game model ----------------
  int         m_phase = P_IDLE;
  int         m_left  = 0;
  int         m_pos   = 0;
  int         m_round = 0;
  int         m_score = 0;
  int         m_wait  = 0;
  logic [1:0] m_pat[$];
  logic [7:0] m_lfsr  = 8'hA5;
  logic [3:0] m_prev  = 4'b0000;
  logic [3:0] exp_led;

  function automatic logic [3:0] oh(input int v);
    oh = 4'b0001 << v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    logic ev;
    if (rst) begin
      m_phase = P_IDLE; m_left = 0; m_pos = 0; m_round = 0; m_score = 0;
      m_wait = 0; m_pat.delete(); m_lfsr = 8'hA5; m_prev = 4'b0000;
    end else begin
      ev = (m_prev == 4'b0000) && (btn != 4'b0000);
      case (m_phase)
        P_IDLE, P_WIN, P_LOSE: begin
          if (start) begin
            m_phase = P_GEN; m_round = 1; m_score = 0; m_pat.delete();
          end
        end
        P_GEN: begin
          m_pat.push_back(m_lfsr[1:0]);
          m_phase = P_ON; m_pos = 0; m_left = ON_TICKS;
        end
        P_ON: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_OFF; m_left = OFF_TICKS; end
        end
        P_OFF: begin
          m_left--;
          if (m_left == 0) begin
            if (m_pos == m_round - 1) begin
              m_phase = P_WAIT; m_pos = 0; m_wait = 0;
            end else begin
              m_pos++; m_phase = P_ON; m_left = ON_TICKS;
            end
          end
        end
        P_WAIT: begin
          if (ev) begin
            if (btn == oh(int'(m_pat[m_pos]))) begin
              m_wait = 0;
              if (m_pos == m_round - 1) begin
                if (m_score < MAX_LEN) m_score++;
                if (m_round == MAX_LEN) m_phase = P_WIN;
                else begin m_round++; m_phase = P_GEN; end
              end else begin
                m_pos++;
              end
            end else begin
              m_phase = P_LOSE;
            end
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT_TICKS) m_phase = P_LOSE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      m_prev = btn;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    model_step();
    chk_en = 1'b1;
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      case (m_phase)
        P_ON:    exp_led = oh(int'(m_pat[m_pos]));
        P_WAIT:  exp_led = btn;
        P_WIN:   exp_led = 4'b1111;
        default: exp_led = 4'b0000;
      endcase
      check("led",   int'(led),   int'(exp_led));
      check("busy",  int'(busy),  int'(!(m_phase inside {P_IDLE, P_WIN, P_LOSE})));
      check("win",   int'(win),   int'(m_phase == P_WIN));
      check("lose",  int'(lose),  int'(m_phase == P_LOSE));
      check("round", int'(round), m_round);
      check("score", int'(score), m_score);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    tick();
    btn = 4'b0000;
    tick();
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      total++;
      bad++;
      $display("FAIL wait_phase cyc=%0d got=%0d exp=%0d", cyc, m_phase, p);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("rst_round", int'(round), 0);
    check("rst_led", int'(led), 0);

    // First game: start in cycle 10, LFSR value of cycle 11 is 8'h77 -> button 3.
    while (cyc < 10) tick();
    pulse_start();
    check("c11_busy", int'(busy), 1);
    check("c11_led", int'(led), 0);
    tick();
    check("c12_led", int'(led), 8);
    repeat (3) tick();
    check("c15_led", int'(led), 8);
    tick();
    check("c16_led", int'(led), 0);
    check("pat0", int'(m_pat[0]), 3);

    // Round 1 correct, then round 2 replays step 0 unchanged.
    wait_phase(P_WAIT, 50);
    press(oh(int'(m_pat[0])));
    check("r2_score", int'(score), 1);
    check("r2_round", int'(round), 2);
    check("r2_step0", int'(led), 8);

    // Round 2 wrong button on step 0.
    wait_phase(P_WAIT, 100);
    press(oh((int'(m_pat[0]) + 1) % 4));
    check("wrong_lose", int'(lose), 1);
    check("wrong_led", int'(led), 0);
    check("wrong_busy", int'(busy), 0);
    check("wrong_score", int'(score), 1);

    // Timeout: no press at all.
    pulse_start();
    wait_phase(P_WAIT, 50);
    n = 0;
    while (!lose && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 64);

    // Press on the last allowed cycle is accepted.
    pulse_start();
    wait_phase(P_WAIT, 50);
    repeat (63) tick();
    btn = oh(int'(m_pat[0]));
    tick();
    check("late_lose", int'(lose), 0);
    check("late_round", int'(round), 2);
    btn = 4'b0000;
    tick();

    // Wrong button held through playback into WAIT_IN must not count.
    wait_phase(P_ON, 20);
    btn = oh((int'(m_pat[0]) + 1) % 4);
    wait_phase(P_WAIT, 100);
    repeat (5) tick();
    check("held_lose", int'(lose), 0);
    btn = 4'b0000;
    tick();
    press(oh(int'(m_pat[0])));
    press(oh(int'(m_pat[1])));
    check("win_win", int'(win), 1);
    check("win_led", int'(led), 15);
    check("win_score", int'(score), 2);
    check("win_busy", int'(busy), 0);

    // New game from WIN.
    pulse_start();
    check("new_round", int'(round), 1);
    check("new_score", int'(score), 0);
    check("new_busy", int'(busy), 1);

    // Multi-hot press.
    wait_phase(P_WAIT, 50);
    press(4'b0011);
    check("multi_lose", int'(lose), 1);

    // Reset in the middle of playback.
    pulse_start();
    wait_phase(P_ON, 20);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_led", int'(led), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_round", int'(round), 0);
    rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
